// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared types and constants for the CPU sequencer
// States, memory command encoding, register/writeback selects and opcodes.
package cpu_sequencer_pkg;

    typedef enum logic [4:0] {
        S_RESET, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM,
        S_GETA, S_GETB, S_ALU, S_CMP, S_WREG,
        S_ADDR, S_LADDR, S_RD, S_LWB,
        S_SGETB, S_SPASS, S_WR, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10
    } mem_cmd_t;

    localparam logic [1:0] REG_RN = 2'b00;
    localparam logic [1:0] REG_RD = 2'b01;
    localparam logic [1:0] REG_RM = 2'b10;

    localparam logic [1:0] WB_C      = 2'b00;
    localparam logic [1:0] WB_PC     = 2'b01;
    localparam logic [1:0] WB_SXIMM8 = 2'b10;
    localparam logic [1:0] WB_MDATA  = 2'b11;

    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;
    localparam logic [2:0] OP_LDR = 3'b011;
    localparam logic [2:0] OP_STR = 3'b100;
    localparam logic [2:0] OP_HLT = 3'b111;

    function automatic logic is_wait(input state_t s);
        return (s == S_IF1) || (s == S_RD) || (s == S_WR);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - decoder/datapath/memory control bundle of the sequencer
// The master side is the sequencer; the slave side is decoder, datapath and memory.
interface cpu_sequencer_if;
    import cpu_sequencer_pkg::*;

    logic [2:0] opcode;
    logic [1:0] op;
    logic       mem_ready;
    mem_cmd_t   mem_cmd;
    logic       addr_sel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en;
    logic       en_A;
    logic       en_B;
    logic       en_C;
    logic       en_status;
    logic       sel_A;
    logic       sel_B;
    logic       halted;
    logic       mem_err;

    modport master (
        input  opcode, op, mem_ready,
        output mem_cmd, addr_sel, load_ir, load_pc, reset_pc, load_addr,
               reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
               sel_A, sel_B, halted, mem_err
    );

    modport slave (
        output opcode, op, mem_ready,
        input  mem_cmd, addr_sel, load_ir, load_pc, reset_pc, load_addr,
               reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
               sel_A, sel_B, halted, mem_err
    );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - Moore FSM driving fetch/decode/execute of the CPU datapath
// Outputs depend only on state and registered flags; inputs only steer the next state.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int WAIT_LIMIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    cpu_sequencer_if.master  bus
);

    state_t      state;
    state_t      next_state;
    logic [15:0] wait_cnt;
    logic        mem_err_q;
    logic        pass_a;
    logic        limit_hit;
    logic        timeout;

    assign limit_hit = (WAIT_LIMIT > 0) && (wait_cnt == 16'(WAIT_LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RESET;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
            pass_a    <= 1'b0;
        end else begin
            state <= next_state;
            if (timeout)
                mem_err_q <= 1'b1;
            if (is_wait(state) && !bus.mem_ready)
                wait_cnt <= wait_cnt + 16'd1;
            else
                wait_cnt <= '0;
            // MOV reg and MVN pass B through the ALU with a zero A operand
            if (state == S_DEC)
                pass_a <= ({bus.opcode, bus.op} == {OP_MOV, 2'b00}) ||
                          ({bus.opcode, bus.op} == {OP_ALU, 2'b11});
        end
    end

    always_comb begin
        next_state    = state;
        timeout       = 1'b0;
        bus.mem_cmd   = CMD_NONE;
        bus.addr_sel  = 1'b0;
        bus.load_ir   = 1'b0;
        bus.load_pc   = 1'b0;
        bus.reset_pc  = 1'b0;
        bus.load_addr = 1'b0;
        bus.reg_sel   = REG_RN;
        bus.wb_sel    = WB_C;
        bus.w_en      = 1'b0;
        bus.en_A      = 1'b0;
        bus.en_B      = 1'b0;
        bus.en_C      = 1'b0;
        bus.en_status = 1'b0;
        bus.sel_A     = 1'b0;
        bus.sel_B     = 1'b0;
        bus.halted    = 1'b0;
        bus.mem_err   = mem_err_q;

        case (state)
            S_RESET: begin
                bus.reset_pc = 1'b1;
                bus.load_pc  = 1'b1;
                next_state   = S_IF1;
            end
            S_IF1: begin
                bus.mem_cmd  = CMD_READ;
                bus.addr_sel = 1'b1;
                if (bus.mem_ready)
                    next_state = S_IF2;
                else if (limit_hit) begin
                    timeout    = 1'b1;
                    next_state = S_HALT;
                end
            end
            S_IF2: begin
                bus.mem_cmd  = CMD_READ;
                bus.addr_sel = 1'b1;
                bus.load_ir  = 1'b1;
                next_state   = S_UPC;
            end
            S_UPC: begin
                bus.load_pc = 1'b1;
                next_state  = S_DEC;
            end
            S_DEC: begin
                case ({bus.opcode, bus.op})
                    {OP_MOV, 2'b10}: next_state = S_WIMM;
                    {OP_MOV, 2'b00}: next_state = S_GETB;
                    {OP_ALU, 2'b11}: next_state = S_GETB;
                    {OP_ALU, 2'b00}: next_state = S_GETA;
                    {OP_ALU, 2'b01}: next_state = S_GETA;
                    {OP_ALU, 2'b10}: next_state = S_GETA;
                    {OP_LDR, 2'b00}: next_state = S_GETA;
                    {OP_STR, 2'b00}: next_state = S_GETA;
                    default:         next_state = S_HALT;
                endcase
            end
            S_WIMM: begin
                bus.reg_sel = REG_RN;
                bus.wb_sel  = WB_SXIMM8;
                bus.w_en    = 1'b1;
                next_state  = S_IF1;
            end
            S_GETA: begin
                bus.reg_sel = REG_RN;
                bus.en_A    = 1'b1;
                next_state  = (bus.opcode == OP_LDR || bus.opcode == OP_STR) ? S_ADDR : S_GETB;
            end
            S_GETB: begin
                bus.reg_sel = REG_RM;
                bus.en_B    = 1'b1;
                next_state  = ({bus.opcode, bus.op} == {OP_ALU, 2'b01}) ? S_CMP : S_ALU;
            end
            S_ALU: begin
                bus.en_C   = 1'b1;
                bus.sel_A  = pass_a;
                next_state = S_WREG;
            end
            S_CMP: begin
                bus.en_status = 1'b1;
                next_state    = S_IF1;
            end
            S_WREG: begin
                bus.reg_sel = REG_RD;
                bus.wb_sel  = WB_C;
                bus.w_en    = 1'b1;
                next_state  = S_IF1;
            end
            S_ADDR: begin
                bus.sel_B  = 1'b1;
                bus.en_C   = 1'b1;
                next_state = S_LADDR;
            end
            S_LADDR: begin
                bus.load_addr = 1'b1;
                next_state    = (bus.opcode == OP_STR) ? S_SGETB : S_RD;
            end
            S_RD: begin
                bus.mem_cmd = CMD_READ;
                if (bus.mem_ready)
                    next_state = S_LWB;
                else if (limit_hit) begin
                    timeout    = 1'b1;
                    next_state = S_HALT;
                end
            end
            S_LWB: begin
                bus.mem_cmd = CMD_READ;
                bus.reg_sel = REG_RD;
                bus.wb_sel  = WB_MDATA;
                bus.w_en    = 1'b1;
                next_state  = S_IF1;
            end
            S_SGETB: begin
                bus.reg_sel = REG_RD;
                bus.en_B    = 1'b1;
                next_state  = S_SPASS;
            end
            S_SPASS: begin
                bus.sel_A  = 1'b1;
                bus.en_C   = 1'b1;
                next_state = S_WR;
            end
            S_WR: begin
                bus.mem_cmd = CMD_WRITE;
                if (bus.mem_ready)
                    next_state = S_IF1;
                else if (limit_hit) begin
                    timeout    = 1'b1;
                    next_state = S_HALT;
                end
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: next_state = S_HALT;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed per-cycle output checks of cpu_sequencer
// Expected output words per state are hand-built from the control table.
module tb_cpu_sequencer;

    logic clk;
    logic rst;

    cpu_sequencer_if bus ();

    cpu_sequencer #(.WAIT_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [19:0] F_READ  = 20'h40000;
    localparam logic [19:0] F_WRITE = 20'h80000;
    localparam logic [19:0] F_ASEL  = 20'h20000;
    localparam logic [19:0] F_LIR   = 20'h10000;
    localparam logic [19:0] F_LPC   = 20'h08000;
    localparam logic [19:0] F_RPC   = 20'h04000;
    localparam logic [19:0] F_LADDR = 20'h02000;
    localparam logic [19:0] F_RM    = 20'h01000;
    localparam logic [19:0] F_RD    = 20'h00800;
    localparam logic [19:0] F_SX    = 20'h00400;
    localparam logic [19:0] F_MD    = 20'h00600;
    localparam logic [19:0] F_WEN   = 20'h00100;
    localparam logic [19:0] F_EA    = 20'h00080;
    localparam logic [19:0] F_EB    = 20'h00040;
    localparam logic [19:0] F_EC    = 20'h00020;
    localparam logic [19:0] F_ES    = 20'h00010;
    localparam logic [19:0] F_SA    = 20'h00008;
    localparam logic [19:0] F_SB    = 20'h00004;
    localparam logic [19:0] F_HALT  = 20'h00002;
    localparam logic [19:0] F_ERR   = 20'h00001;

    localparam logic [19:0] E_RESET = F_RPC | F_LPC;
    localparam logic [19:0] E_IF1   = F_READ | F_ASEL;
    localparam logic [19:0] E_IF2   = F_READ | F_ASEL | F_LIR;
    localparam logic [19:0] E_UPC   = F_LPC;
    localparam logic [19:0] E_DEC   = 20'h00000;
    localparam logic [19:0] E_WIMM  = F_SX | F_WEN;
    localparam logic [19:0] E_GETA  = F_EA;
    localparam logic [19:0] E_GETB  = F_RM | F_EB;
    localparam logic [19:0] E_ALU   = F_EC;
    localparam logic [19:0] E_ALUP  = F_EC | F_SA;
    localparam logic [19:0] E_CMP   = F_ES;
    localparam logic [19:0] E_WREG  = F_RD | F_WEN;
    localparam logic [19:0] E_ADDR  = F_SB | F_EC;
    localparam logic [19:0] E_LADDR = F_LADDR;
    localparam logic [19:0] E_RDW   = F_READ;
    localparam logic [19:0] E_LWB   = F_READ | F_RD | F_MD | F_WEN;
    localparam logic [19:0] E_SGETB = F_RD | F_EB;
    localparam logic [19:0] E_SPASS = F_SA | F_EC;
    localparam logic [19:0] E_WR    = F_WRITE;
    localparam logic [19:0] E_HALT  = F_HALT;

    logic [19:0] obs;
    assign obs = {bus.mem_cmd, bus.addr_sel, bus.load_ir, bus.load_pc, bus.reset_pc,
                  bus.load_addr, bus.reg_sel, bus.wb_sel, bus.w_en, bus.en_A, bus.en_B,
                  bus.en_C, bus.en_status, bus.sel_A, bus.sel_B, bus.halted, bus.mem_err};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [19:0] q_exp[$];
    logic        q_rdy[$];

    task automatic add(input logic [19:0] e, input logic r);
        q_exp.push_back(e);
        q_rdy.push_back(r);
    endtask

    task automatic fetch();
        add(E_IF1, 1'b1);
        add(E_IF2, 1'b1);
        add(E_UPC, 1'b1);
        add(E_DEC, 1'b1);
    endtask

    task automatic run(input string tag);
        for (int i = 0; i < q_exp.size(); i++) begin
            bus.mem_ready = q_rdy[i];
            check($sformatf("%s[%0d]", tag, i), {12'h000, obs}, {12'h000, q_exp[i]});
            @(posedge clk);
            #1;
        end
        q_exp.delete();
        q_rdy.delete();
    endtask

    task automatic set_instr(input logic [2:0] opc, input logic [1:0] o);
        bus.opcode = opc;
        bus.op     = o;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rst"}, {12'h000, obs}, {12'h000, E_RESET});
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_if1"}, {12'h000, obs}, {12'h000, E_IF1});
    endtask

    initial begin
        rst = 1'b1;
        bus.opcode = 3'b000;
        bus.op = 2'b00;
        bus.mem_ready = 1'b0;
        #1;
        check("reset_async", {12'h000, obs}, {12'h000, E_RESET});
        @(posedge clk);
        #1;
        check("reset_hold", {12'h000, obs}, {12'h000, E_RESET});
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_if1", {12'h000, obs}, {12'h000, E_IF1});

        set_instr(3'b110, 2'b10);
        fetch(); add(E_WIMM, 1'b1);
        run("mov_imm");

        set_instr(3'b101, 2'b00);
        fetch(); add(E_GETA, 1'b1); add(E_GETB, 1'b1); add(E_ALU, 1'b1); add(E_WREG, 1'b1);
        run("add");

        set_instr(3'b101, 2'b10);
        fetch(); add(E_GETA, 1'b0); add(E_GETB, 1'b0); add(E_ALU, 1'b1); add(E_WREG, 1'b0);
        run("and");

        set_instr(3'b101, 2'b01);
        fetch(); add(E_GETA, 1'b1); add(E_GETB, 1'b1); add(E_CMP, 1'b1);
        run("cmp");

        set_instr(3'b101, 2'b11);
        fetch(); add(E_GETB, 1'b1); add(E_ALUP, 1'b1); add(E_WREG, 1'b1);
        run("mvn");

        set_instr(3'b110, 2'b00);
        add(E_IF1, 1'b0); add(E_IF1, 1'b0);
        fetch(); add(E_GETB, 1'b1); add(E_ALUP, 1'b1); add(E_WREG, 1'b1);
        run("mov_reg");

        set_instr(3'b011, 2'b00);
        fetch(); add(E_GETA, 1'b1); add(E_ADDR, 1'b1); add(E_LADDR, 1'b1);
        add(E_RDW, 1'b0); add(E_RDW, 1'b0); add(E_RDW, 1'b0); add(E_RDW, 1'b1);
        add(E_LWB, 1'b1);
        run("ldr_wait");

        set_instr(3'b100, 2'b00);
        fetch(); add(E_GETA, 1'b1); add(E_ADDR, 1'b1); add(E_LADDR, 1'b1);
        add(E_SGETB, 1'b1); add(E_SPASS, 1'b1); add(E_WR, 1'b1);
        run("str");

        fetch(); add(E_GETA, 1'b1); add(E_ADDR, 1'b1); add(E_LADDR, 1'b1);
        add(E_SGETB, 1'b1); add(E_SPASS, 1'b1);
        add(E_WR, 1'b0); add(E_WR, 1'b0); add(E_WR, 1'b0); add(E_WR, 1'b1);
        run("str_limit_ready");

        set_instr(3'b101, 2'b00);
        fetch(); add(E_GETA, 1'b1); add(E_GETB, 1'b1);
        run("add_pre_rst");
        check("add_in_alu", {12'h000, obs}, {12'h000, E_ALU});
        do_reset("mid_alu");

        set_instr(3'b100, 2'b00);
        fetch(); add(E_GETA, 1'b1); add(E_ADDR, 1'b1); add(E_LADDR, 1'b1);
        add(E_SGETB, 1'b1); add(E_SPASS, 1'b1);
        add(E_WR, 1'b0); add(E_WR, 1'b0); add(E_WR, 1'b0); add(E_WR, 1'b0);
        add(E_HALT | F_ERR, 1'b0); add(E_HALT | F_ERR, 1'b1); add(E_HALT | F_ERR, 1'b0);
        run("str_timeout");
        do_reset("after_timeout");

        set_instr(3'b111, 2'b01);
        fetch(); add(E_HALT, 1'b1); add(E_HALT, 1'b0); add(E_HALT, 1'b1);
        run("halt");
        do_reset("after_halt");

        set_instr(3'b110, 2'b01);
        fetch(); add(E_HALT, 1'b1); add(E_HALT, 1'b1);
        run("illegal");
        do_reset("after_illegal");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
